// File: rtl/exec_dispatcher.sv
// exec_dispatcher: assigns scheduled transactions to free execution lanes, holds each
// on a lane-tagged dispatch register until taken, tracks per-lane completion and
// returns retired program IDs through a small retire FIFO.
// Optional feature: define DISPATCHER_HAZARD_CHECK_EN to stall inputs whose
// dependency sets conflict with lanes still in DISPATCH or EXEC.
module exec_dispatcher #(
    parameter int unsigned NUM_LANES         = 4,
    parameter int unsigned MAX_DEPENDENCIES  = 1024,
    parameter int unsigned RETIRE_FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [63:0]                   s_axis_tdata_owner_programID,
    input  logic [MAX_DEPENDENCIES-1:0]   s_axis_tdata_read_dependencies,
    input  logic [MAX_DEPENDENCIES-1:0]   s_axis_tdata_write_dependencies,
    output logic                          dispatch_valid,
    input  logic                          dispatch_ready,
    output logic [$clog2(NUM_LANES)-1:0]  dispatch_lane,
    output logic [63:0]                   dispatch_programID,
    output logic [MAX_DEPENDENCIES-1:0]   dispatch_read_dependencies,
    output logic [MAX_DEPENDENCIES-1:0]   dispatch_write_dependencies,
    input  logic [NUM_LANES-1:0]          lane_done,
    output logic                          m_retire_tvalid,
    input  logic                          m_retire_tready,
    output logic [63:0]                   m_retire_programID,
    output logic [NUM_LANES-1:0]          lanes_busy,
    output logic [31:0]                   retired_count,
    output logic [31:0]                   hazard_stalls
);

    localparam int unsigned LANE_W = $clog2(NUM_LANES);
    localparam int unsigned PTR_W  = $clog2(RETIRE_FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        LANE_FREE     = 2'd0,
        LANE_DISPATCH = 2'd1,
        LANE_EXEC     = 2'd2,
        LANE_DONE     = 2'd3
    } lane_state_e;

    lane_state_e          lane_state     [NUM_LANES];
    lane_state_e          lane_state_nxt [NUM_LANES];
    logic [63:0]          lane_pid       [NUM_LANES];
    logic [NUM_LANES-1:0] busy_nxt;

    logic                 free_found;
    logic [LANE_W-1:0]    free_lane;
    logic                 done_found;
    logic [LANE_W-1:0]    done_lane;

    logic                 hazard;
    logic                 accept;
    logic                 disp_hs;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;

    logic [63:0]          fifo_mem [RETIRE_FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     fifo_cnt;

    // Lowest-index FREE lane for allocation and lowest-index DONE lane for retire push
    always_comb begin
        free_found = 1'b0;
        free_lane  = '0;
        done_found = 1'b0;
        done_lane  = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (!free_found && lane_state[i] == LANE_FREE) begin
                free_found = 1'b1;
                free_lane  = LANE_W'(i);
            end
            if (!done_found && lane_state[i] == LANE_DONE) begin
                done_found = 1'b1;
                done_lane  = LANE_W'(i);
            end
        end
    end

`ifdef DISPATCHER_HAZARD_CHECK_EN
    logic [MAX_DEPENDENCIES-1:0] lane_rd [NUM_LANES];
    logic [MAX_DEPENDENCIES-1:0] lane_wr [NUM_LANES];
    logic [31:0]                 stall_cnt;

    // Conflict of the offered input against every lane still in DISPATCH or EXEC
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if ((lane_state[i] == LANE_DISPATCH || lane_state[i] == LANE_EXEC) &&
                ((|(s_axis_tdata_write_dependencies & (lane_rd[i] | lane_wr[i]))) ||
                 (|(s_axis_tdata_read_dependencies & lane_wr[i])))) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard & s_axis_tvalid;
    end

    // Per-lane dependency table, captured on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                lane_rd[i] <= '0;
                lane_wr[i] <= '0;
            end
        end else if (accept) begin
            lane_rd[free_lane] <= s_axis_tdata_read_dependencies;
            lane_wr[free_lane] <= s_axis_tdata_write_dependencies;
        end
    end

    // Cycles in which the input is held back by a hazard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (hazard) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign hazard_stalls = stall_cnt;
`else
    assign hazard        = 1'b0;
    assign hazard_stalls = '0;
`endif

    assign s_axis_tready   = free_found & ~dispatch_valid & ~hazard;
    assign accept          = s_axis_tvalid & s_axis_tready;
    assign disp_hs         = dispatch_valid & dispatch_ready;
    assign fifo_full       = (fifo_cnt == CNT_W'(RETIRE_FIFO_DEPTH));
    assign m_retire_tvalid = (fifo_cnt != '0);
    assign pop             = m_retire_tvalid & m_retire_tready;
    assign push            = done_found & (~fifo_full | pop);
    assign m_retire_programID = fifo_mem[rd_ptr];

    // Per-lane next state: FREE -> DISPATCH -> EXEC -> DONE -> FREE
    always_comb begin
        busy_nxt = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_state_nxt[i] = lane_state[i];
            case (lane_state[i])
                LANE_FREE: begin
                    if (accept && free_lane == LANE_W'(i)) lane_state_nxt[i] = LANE_DISPATCH;
                end
                LANE_DISPATCH: begin
                    if (disp_hs && dispatch_lane == LANE_W'(i)) lane_state_nxt[i] = LANE_EXEC;
                end
                LANE_EXEC: begin
                    if (lane_done[i]) lane_state_nxt[i] = LANE_DONE;
                end
                LANE_DONE: begin
                    if (push && done_lane == LANE_W'(i)) lane_state_nxt[i] = LANE_FREE;
                end
                default: lane_state_nxt[i] = LANE_FREE;
            endcase
            busy_nxt[i] = (lane_state_nxt[i] != LANE_FREE);
        end
    end

    // Lane state register and registered busy map
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) lane_state[i] <= LANE_FREE;
            lanes_busy <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_LANES; i++) lane_state[i] <= lane_state_nxt[i];
            lanes_busy <= busy_nxt;
        end
    end

    // Program ID table, captured on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) lane_pid[i] <= '0;
        end else if (accept) begin
            lane_pid[free_lane] <= s_axis_tdata_owner_programID;
        end
    end

    // Dispatch register, held stable until the execution fabric takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dispatch_valid              <= 1'b0;
            dispatch_lane               <= '0;
            dispatch_programID          <= '0;
            dispatch_read_dependencies  <= '0;
            dispatch_write_dependencies <= '0;
        end else if (accept) begin
            dispatch_valid              <= 1'b1;
            dispatch_lane               <= free_lane;
            dispatch_programID          <= s_axis_tdata_owner_programID;
            dispatch_read_dependencies  <= s_axis_tdata_read_dependencies;
            dispatch_write_dependencies <= s_axis_tdata_write_dependencies;
        end else if (disp_hs) begin
            dispatch_valid <= 1'b0;
        end
    end

    // Retire FIFO; push while full is allowed when a pop frees the slot in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RETIRE_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= lane_pid[done_lane];
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Completed retire handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_count <= '0;
        end else if (pop) begin
            retired_count <= retired_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_exec_dispatcher.sv
// Self-checking bench for exec_dispatcher: directed scenarios plus a randomized
// phase, all compared against a transaction-level reference model.
module tb_exec_dispatcher;

    localparam int unsigned NL = 4;
    localparam int unsigned MD = 1024;
    localparam int unsigned FD = 4;
    localparam int unsigned LW = $clog2(NL);
    localparam int S_FREE = 0;
    localparam int S_DISP = 1;
    localparam int S_EXEC = 2;
    localparam int S_DONE = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [63:0]   s_axis_tdata_owner_programID;
    logic [MD-1:0] s_axis_tdata_read_dependencies;
    logic [MD-1:0] s_axis_tdata_write_dependencies;
    logic          dispatch_valid;
    logic          dispatch_ready;
    logic [LW-1:0] dispatch_lane;
    logic [63:0]   dispatch_programID;
    logic [MD-1:0] dispatch_read_dependencies;
    logic [MD-1:0] dispatch_write_dependencies;
    logic [NL-1:0] lane_done;
    logic          m_retire_tvalid;
    logic          m_retire_tready;
    logic [63:0]   m_retire_programID;
    logic [NL-1:0] lanes_busy;
    logic [31:0]   retired_count;
    logic [31:0]   hazard_stalls;

    exec_dispatcher #(
        .NUM_LANES(NL), .MAX_DEPENDENCIES(MD), .RETIRE_FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata_owner_programID(s_axis_tdata_owner_programID),
        .s_axis_tdata_read_dependencies(s_axis_tdata_read_dependencies),
        .s_axis_tdata_write_dependencies(s_axis_tdata_write_dependencies),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_lane(dispatch_lane), .dispatch_programID(dispatch_programID),
        .dispatch_read_dependencies(dispatch_read_dependencies),
        .dispatch_write_dependencies(dispatch_write_dependencies),
        .lane_done(lane_done),
        .m_retire_tvalid(m_retire_tvalid), .m_retire_tready(m_retire_tready),
        .m_retire_programID(m_retire_programID),
        .lanes_busy(lanes_busy), .retired_count(retired_count),
        .hazard_stalls(hazard_stalls)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: lane status list, dispatch slot, retire queue, counters
    int            m_st  [NL];
    logic [63:0]   m_pid [NL];
    logic [MD-1:0] m_rd  [NL];
    logic [MD-1:0] m_wr  [NL];
    logic          m_dvalid;
    logic [LW-1:0] m_dlane;
    logic [63:0]   m_dpid;
    logic [MD-1:0] m_drd;
    logic [MD-1:0] m_dwr;
    logic [63:0]   m_q[$];
    logic [31:0]   m_retired;
    logic [31:0]   m_stalls;

    // Per-cycle predictions and captured inputs
    int            p_free;
    int            p_done;
    bit            p_hazard, p_tready, p_accept, p_hs, p_pop, p_push;
    bit            dut_acc;
    logic [NL-1:0] c_done;
    logic [63:0]   c_pid;
    logic [MD-1:0] c_rd;
    logic [MD-1:0] c_wr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [MD-1:0] obs, input logic [MD-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed(ones=%0d low=0x%0h) expected(ones=%0d low=0x%0h)",
                   tag, $countones(obs), obs[63:0], $countones(exp), exp[63:0]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_st[i] = S_FREE; m_pid[i] = '0; m_rd[i] = '0; m_wr[i] = '0;
        end
        m_dvalid = 1'b0; m_dlane = '0; m_dpid = '0; m_drd = '0; m_dwr = '0;
        m_q.delete();
        m_retired = '0;
        m_stalls  = '0;
    endtask

    task automatic model_eval();
        p_free = -1;
        p_done = -1;
        for (int i = NL - 1; i >= 0; i--) begin
            if (m_st[i] == S_FREE) p_free = i;
            if (m_st[i] == S_DONE) p_done = i;
        end
        p_hazard = 1'b0;
`ifdef DISPATCHER_HAZARD_CHECK_EN
        if (s_axis_tvalid) begin
            for (int i = 0; i < NL; i++) begin
                if ((m_st[i] == S_DISP || m_st[i] == S_EXEC) &&
                    (((s_axis_tdata_write_dependencies & (m_rd[i] | m_wr[i])) != '0) ||
                     ((s_axis_tdata_read_dependencies & m_wr[i]) != '0)))
                    p_hazard = 1'b1;
            end
        end
`endif
        p_tready = (p_free >= 0) && !m_dvalid && !p_hazard;
        p_accept = s_axis_tvalid && p_tready;
        p_hs     = m_dvalid && dispatch_ready;
        p_pop    = (m_q.size() > 0) && m_retire_tready;
        p_push   = (p_done >= 0) && ((m_q.size() < int'(FD)) || p_pop);
        c_done   = lane_done;
        c_pid    = s_axis_tdata_owner_programID;
        c_rd     = s_axis_tdata_read_dependencies;
        c_wr     = s_axis_tdata_write_dependencies;
        dut_acc  = s_axis_tvalid && s_axis_tready;
    endtask

    task automatic model_update();
        int old_st [NL];
        old_st = m_st;
        if (p_hazard) m_stalls++;
        if (p_pop) begin
            void'(m_q.pop_front());
            m_retired++;
        end
        if (p_push) begin
            m_q.push_back(m_pid[p_done]);
            m_st[p_done] = S_FREE;
        end
        for (int i = 0; i < NL; i++)
            if (old_st[i] == S_EXEC && c_done[i]) m_st[i] = S_DONE;
        if (p_hs) begin
            m_st[m_dlane] = S_EXEC;
            m_dvalid = 1'b0;
        end
        if (p_accept) begin
            m_st[p_free] = S_DISP;
            m_pid[p_free] = c_pid;
            m_rd[p_free]  = c_rd;
            m_wr[p_free]  = c_wr;
            m_dvalid = 1'b1;
            m_dlane  = LW'(p_free);
            m_dpid   = c_pid;
            m_drd    = c_rd;
            m_dwr    = c_wr;
        end
    endtask

    task automatic check_outputs();
        logic [NL-1:0] busy;
        for (int i = 0; i < NL; i++) busy[i] = (m_st[i] != S_FREE);
        check("dispatch_valid", 64'(dispatch_valid), 64'(m_dvalid));
        if (m_dvalid) begin
            check("dispatch_lane", 64'(dispatch_lane), 64'(m_dlane));
            check("dispatch_programID", dispatch_programID, m_dpid);
            check_vec("dispatch_read_deps", dispatch_read_dependencies, m_drd);
            check_vec("dispatch_write_deps", dispatch_write_dependencies, m_dwr);
        end
        check("lanes_busy", 64'(lanes_busy), 64'(busy));
        check("m_retire_tvalid", 64'(m_retire_tvalid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) check("m_retire_programID", m_retire_programID, m_q[0]);
        check("retired_count", 64'(retired_count), 64'(m_retired));
        check("hazard_stalls", 64'(hazard_stalls), 64'(m_stalls));
    endtask

    // One clock: check ready before the edge, advance model, check registered outputs
    task automatic step();
        #1;
        model_eval();
        check("s_axis_tready", 64'(s_axis_tready), 64'(p_tready));
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
        lane_done = '0;
    endtask

    task automatic send(input logic [63:0] pid, input logic [MD-1:0] rd, input logic [MD-1:0] wr);
        int n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata_owner_programID    = pid;
        s_axis_tdata_read_dependencies  = rd;
        s_axis_tdata_write_dependencies = wr;
        do begin
            step();
            n++;
        end while (!dut_acc && n < 40);
        check("send_accept_within_budget", 64'(dut_acc), 64'(1));
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        s_axis_tvalid   = 1'b0;
        dispatch_ready  = 1'b1;
        m_retire_tready = 1'b1;
        repeat (14) begin
            lane_done = '1;
            step();
        end
    endtask

    function automatic logic [MD-1:0] rand_deps();
        logic [MD-1:0] v;
        v = '0;
        repeat ($urandom_range(0, 2)) v[$urandom_range(0, 11)] = 1'b1;
        if ($urandom_range(0, 7) == 0) v[MD-1] = 1'b1;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [MD-1:0] zero_v;
        logic [MD-1:0] bit5;
        logic [63:0]   got[$];
        logic [63:0]   held_pid;

        zero_v = '0;
        bit5   = '0;
        bit5[5] = 1'b1;

        rst_n           = 1'b0;
        s_axis_tvalid   = 1'b0;
        s_axis_tdata_owner_programID    = '0;
        s_axis_tdata_read_dependencies  = '0;
        s_axis_tdata_write_dependencies = '0;
        dispatch_ready  = 1'b0;
        lane_done       = '0;
        m_retire_tready = 1'b0;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_dispatch_valid", 64'(dispatch_valid), 64'(0));
        check("rst_dispatch_programID", dispatch_programID, 64'(0));
        check_vec("rst_dispatch_read", dispatch_read_dependencies, zero_v);
        check("rst_m_retire_tvalid", 64'(m_retire_tvalid), 64'(0));
        check("rst_m_retire_programID", m_retire_programID, 64'(0));
        check("rst_lanes_busy", 64'(lanes_busy), 64'(0));
        check("rst_retired_count", 64'(retired_count), 64'(0));
        rst_n = 1'b1;
        #1;
        check("tready_after_release", 64'(s_axis_tready), 64'(1));

        // Single transaction 0x11 on lane 0, retire two cycles after lane_done
        dispatch_ready = 1'b1;
        send(64'h11, zero_v, zero_v);
        check("t1_lane", 64'(dispatch_lane), 64'(0));
        check("t1_pid", dispatch_programID, 64'h11);
        step();
        step();
        lane_done = 4'b0001;
        step();
        step();
        check("t1_retire_valid", 64'(m_retire_tvalid), 64'(1));
        check("t1_retire_pid", m_retire_programID, 64'h11);
        m_retire_tready = 1'b1;
        step();
        check("t1_retired_count", 64'(retired_count), 64'(1));

        // Fill all four lanes, fifth waits, then takes the freed lane 2
        for (int k = 0; k < 4; k++) send(64'h100 + 64'(k), zero_v, zero_v);
        check("t2_all_busy", 64'(lanes_busy), 64'hF);
        step();
        s_axis_tvalid = 1'b1;
        s_axis_tdata_owner_programID = 64'h200;
        repeat (3) begin
            step();
            check("t2_full_tready", 64'(s_axis_tready), 64'(0));
        end
        lane_done = 4'b0100;
        step();
        step();
        send(64'h200, zero_v, zero_v);
        check("t2_freed_lane", 64'(dispatch_lane), 64'(2));
        step();
        lane_done = 4'b1111;
        step();
        repeat (6) step();
        check("t2_idle", 64'(lanes_busy), 64'(0));
        check("t2_retired_count", 64'(retired_count), 64'(6));

        // Dispatch held for 5 cycles; lane_done on the DISPATCH lane is ignored
        dispatch_ready = 1'b0;
        send(64'h300, bit5, zero_v);
        held_pid = 64'h300;
        lane_done = 4'b0001;
        repeat (5) begin
            step();
            check("t3_hold_pid", dispatch_programID, held_pid);
            check("t3_hold_lane", 64'(dispatch_lane), 64'(0));
            check("t3_hold_tready", 64'(s_axis_tready), 64'(0));
        end
        dispatch_ready = 1'b1;
        step();
        step();
        step();
        check("t3_no_retire", 64'(m_retire_tvalid), 64'(0));
        lane_done = 4'b0001;
        step();
        step();
        step();
        check("t3_retired_count", 64'(retired_count), 64'(7));

        // Six completions into a depth-4 FIFO with the consumer stalled
        m_retire_tready = 1'b0;
        for (int k = 0; k < 4; k++) send(64'h400 + 64'(k), zero_v, zero_v);
        step();
        lane_done = 4'b1111;
        step();
        repeat (4) step();
        send(64'h404, zero_v, zero_v);
        send(64'h405, zero_v, zero_v);
        step();
        lane_done = 4'b0011;
        step();
        step();
        step();
        check("t4_done_waiting", 64'(lanes_busy), 64'h3);
        check("t4_fifo_head", m_retire_programID, 64'h400);
        m_retire_tready = 1'b1;
        got.delete();
        repeat (12) begin
            if (m_retire_tvalid) got.push_back(m_retire_programID);
            step();
        end
        check("t4_retire_total", 64'(got.size()), 64'(6));
        for (int k = 0; k < 6; k++)
            if (k < got.size()) check("t4_retire_order", got[k], 64'h400 + 64'(k));
        check("t4_retired_count", 64'(retired_count), 64'(13));

`ifdef DISPATCHER_HAZARD_CHECK_EN
        // EXEC lane writes bit 5; a reader of bit 5 stalls until that lane is DONE
        send(64'h500, zero_v, bit5);
        step();
        s_axis_tvalid = 1'b1;
        s_axis_tdata_owner_programID    = 64'h501;
        s_axis_tdata_read_dependencies  = bit5;
        s_axis_tdata_write_dependencies = zero_v;
        repeat (3) step();
        check("t5_stall_tready", 64'(s_axis_tready), 64'(0));
        check("t5_stalls3", 64'(hazard_stalls), 64'(3));
        lane_done = 4'b0001;
        step();
        send(64'h501, bit5, zero_v);
        check("t5_stalls_final", 64'(hazard_stalls), 64'(4));
        check("t5_pid", dispatch_programID, 64'h501);
        drain();
`endif

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            s_axis_tvalid = 1'($urandom_range(0, 1));
            s_axis_tdata_owner_programID    = {32'($urandom), 32'($urandom)};
            s_axis_tdata_read_dependencies  = rand_deps();
            s_axis_tdata_write_dependencies = rand_deps();
            dispatch_ready  = ($urandom_range(0, 9) < 6);
            m_retire_tready = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < NL; i++) lane_done[i] = ($urandom_range(0, 4) == 0);
            step();
        end
        drain();

        // Asynchronous reset with three lanes busy and a dispatch pending
        dispatch_ready = 1'b1;
        send(64'hA0, zero_v, zero_v);
        send(64'hA1, zero_v, zero_v);
        send(64'hA2, zero_v, zero_v);
        dispatch_ready = 1'b0;
        check("t6_three_busy", 64'(lanes_busy), 64'h7);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_dispatch_valid", 64'(dispatch_valid), 64'(0));
        check("t6_dispatch_programID", dispatch_programID, 64'(0));
        check("t6_lanes_busy", 64'(lanes_busy), 64'(0));
        check("t6_m_retire_tvalid", 64'(m_retire_tvalid), 64'(0));
        check("t6_retired_count", 64'(retired_count), 64'(0));
        check("t6_hazard_stalls", 64'(hazard_stalls), 64'(0));
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("t6_tready_after_release", 64'(s_axis_tready), 64'(1));
        dispatch_ready = 1'b1;
        send(64'hB0, zero_v, zero_v);
        check("t6_lane_after_reset", 64'(dispatch_lane), 64'(0));
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
